// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the DataMemory arbiter: state encoding, default
// fairness parameters and a counter-width helper.
package data_mem_arbiter_pkg;

    // Which requester owns DataMemory by default this cycle.
    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DBG = 1'b1
    } arb_state_t;

    // Debug may be refused this many cycles before a forced debug window.
    localparam int DEF_MAX_WAIT  = 4;
    // Maximum consecutive debug grants inside one forced window.
    localparam int DEF_BURST_MAX = 4;

    // Bits needed for a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the debug
// wait counter and the forced-window burst counter.
module data_mem_arbiter_sat_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values.
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port DataMemory between the CPU MEM stage (priority)
// and a debug/loader port, with a bounded wait and short forced debug
// windows so the host cannot be starved by a busy pipeline.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              reset,
    // CPU MEM stage
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // debug / loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    // DataMemory
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W  = cnt_width(MAX_WAIT);
    localparam int BURST_W = cnt_width(BURST_MAX);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               wait_clear;
    logic               wait_inc;
    logic               burst_clear;
    logic               burst_inc;
    logic               sel_cpu;
    logic               sel_dbg;

    // Cycles the pending debug request has been refused in ARB_CPU.
    data_mem_arbiter_sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (wait_clear),
        .inc   (wait_inc),
        .count (wait_cnt)
    );

    // Debug grants issued inside the current forced window.
    data_mem_arbiter_sat_counter #(.WIDTH(BURST_W)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (burst_clear),
        .inc   (burst_inc),
        .count (burst_cnt)
    );

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_CPU;
        end else begin
            state <= state_next;
        end
    end

    // Next state, requester selection, handshakes and counter control.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_next  = state;
        sel_cpu     = 1'b0;
        sel_dbg     = 1'b0;
        dbg_gnt     = 1'b0;
        cpu_stall   = 1'b0;
        wait_clear  = 1'b0;
        wait_inc    = 1'b0;
        burst_clear = 1'b0;
        burst_inc   = 1'b0;
        if (!reset) begin
            unique case (state)
                ARB_CPU: begin
                    burst_clear = 1'b1;
                    if (cpu_req) begin
                        sel_cpu = 1'b1;
                        if (dbg_req) begin
                            // Debug refused; after MAX_WAIT refusals force a window.
                            wait_inc = 1'b1;
                            if (wait_cnt == WAIT_LAST) begin
                                state_next = ARB_DBG;
                            end
                        end else begin
                            wait_clear = 1'b1;
                        end
                    end else begin
                        // Idle CPU slot: serve debug opportunistically.
                        wait_clear = 1'b1;
                        if (dbg_req) begin
                            sel_dbg = 1'b1;
                            dbg_gnt = 1'b1;
                        end
                    end
                end
                ARB_DBG: begin
                    cpu_stall  = cpu_req;
                    wait_clear = 1'b1;
                    if (dbg_req) begin
                        sel_dbg   = 1'b1;
                        dbg_gnt   = 1'b1;
                        burst_inc = 1'b1;
                        if (burst_cnt == BURST_LAST) begin
                            state_next  = ARB_CPU;
                            burst_clear = 1'b1;
                        end
                    end else begin
                        // Host has nothing more to do; hand memory back early.
                        state_next  = ARB_CPU;
                        burst_clear = 1'b1;
                    end
                end
                default: state_next = ARB_CPU;
            endcase
        end
    end

    // Route the selected requester onto DataMemory; idle bus drives zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (sel_cpu) begin
            mem_we    = cpu_we;
            mem_re    = ~cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end else if (sel_dbg) begin
            mem_we    = dbg_we;
            mem_re    = ~dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Capture debug read data; rvalid pulses the cycle after a granted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the arbitration rules and of DataMemory contents.
module tb_data_mem_arbiter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 4;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    data_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory stand-in: combinational read, write committed on the edge.
    logic [DATA_W-1:0] env_mem [0:DEPTH-1];
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) if (mem_we) env_mem[mem_addr] = mem_wdata;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    bit                chk_en = 1'b0;
    bit                m_window = 1'b0;   // inside a forced debug window
    int                m_refusals = 0;    // consecutive refused debug cycles
    int                m_wgrants = 0;     // grants so far in the window
    bit                m_rvalid = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;

    // Compare all outputs every cycle, then advance the model across the next edge.
    always @(negedge clk) begin : cmp
        logic              e_stall, e_we, e_re;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata, e_crd;
        bit                cpu_served, dbg_served;
        if (chk_en) begin
            e_stall = 1'b0; e_we = 1'b0; e_re = 1'b0;
            e_addr = '0; e_wdata = '0; e_crd = '0;
            cpu_served = 1'b0; dbg_served = 1'b0;
            if (!reset) begin
                if (m_window) begin
                    e_stall    = cpu_req;
                    dbg_served = dbg_req;
                end else if (cpu_req) begin
                    cpu_served = 1'b1;
                end else begin
                    dbg_served = dbg_req;
                end
            end
            if (cpu_served) begin
                e_we = cpu_we; e_re = !cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
                e_crd = ref_mem[cpu_addr];
            end else if (dbg_served) begin
                e_we = dbg_we; e_re = !dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata;
            end
            check("dbg_gnt",    dbg_gnt,    dbg_served);
            check("cpu_stall",  cpu_stall,  e_stall);
            check("mem_we",     mem_we,     e_we);
            check("mem_re",     mem_re,     e_re);
            check("mem_addr",   mem_addr,   e_addr);
            check("mem_wdata",  mem_wdata,  e_wdata);
            check("cpu_rdata",  cpu_rdata,  e_crd);
            check("dbg_rvalid", dbg_rvalid, m_rvalid);
            check("dbg_rdata",  dbg_rdata,  m_rdata);

            if (reset) begin
                m_window = 1'b0; m_refusals = 0; m_wgrants = 0;
                m_rvalid = 1'b0; m_rdata = '0;
            end else begin
                m_rvalid = dbg_served && !dbg_we;
                if (dbg_served && !dbg_we) m_rdata = ref_mem[dbg_addr];
                if (e_we) ref_mem[e_addr] = e_wdata;
                if (m_window) begin
                    m_refusals = 0;
                    if (dbg_req) begin
                        m_wgrants++;
                        if (m_wgrants == BURST_MAX) begin
                            m_window = 1'b0; m_wgrants = 0;
                        end
                    end else begin
                        m_window = 1'b0; m_wgrants = 0;
                    end
                end else if (cpu_req && dbg_req) begin
                    m_refusals++;
                    if (m_refusals == MAX_WAIT) begin
                        m_window = 1'b1; m_refusals = 0;
                    end
                end else begin
                    m_refusals = 0;
                end
            end
        end
    end

    // One cycle of stimulus: apply after the edge, return just after the falling edge.
    task automatic drive(input logic rs,
                         input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                         input logic [DATA_W-1:0] cd,
                         input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                         input logic [DATA_W-1:0] dd);
        @(posedge clk); #1;
        reset = rs;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    logic [15:0]       gnt_seen, stall_seen;
    int                ngrant;
    logic              h_req, h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        chk_en = 1'b1;

        // Reset: registered outputs cleared, combinational outputs forced idle.
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        check("rst_rvalid", dbg_rvalid, 1'b0);
        check("rst_rdata",  dbg_rdata,  32'h0);
        drive(1'b1, 1'b1, 1'b1, 10'd3, 32'h1, 1'b1, 1'b1, 10'd4, 32'h2);
        check("rst_mem_we",  mem_we,    1'b0);
        check("rst_mem_re",  mem_re,    1'b0);
        check("rst_gnt",     dbg_gnt,   1'b0);
        check("rst_stall",   cpu_stall, 1'b0);

        // 1. CPU only: write then read back.
        drive(1'b0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        check("t1_we",    mem_we,    1'b1);
        check("t1_addr",  mem_addr,  10'd5);
        check("t1_stall", cpu_stall, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_re",    mem_re,    1'b1);
        check("t1_stall2", cpu_stall, 1'b0);

        // 2. Idle gap: debug read is granted at once, data returns next cycle.
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd5, '0);
        check("t2_gnt", dbg_gnt, 1'b1);
        idle();
        check("t2_rvalid", dbg_rvalid, 1'b1);
        check("t2_rdata",  dbg_rdata,  32'hDEADBEEF);
        idle();
        check("t2_rvalid_drop", dbg_rvalid, 1'b0);
        check("t2_rdata_hold",  dbg_rdata,  32'hDEADBEEF);

        // 6 + 3 + 4. Tie, starvation window, CPU recovery, short burst.
        ngrant = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b1, 1'b0, 10'd5, '0,
                  (c < 14), 1'b1, 10'(16 + ngrant), 32'hA000_0000 + 32'(ngrant));
            gnt_seen[15-c]   = dbg_gnt;
            stall_seen[15-c] = cpu_stall;
            if (dbg_gnt) ngrant++;
            if (c == 0) begin
                check("t6_tie_gnt",   dbg_gnt,   1'b0);
                check("t6_tie_stall", cpu_stall, 1'b0);
                check("t6_tie_rdata", cpu_rdata, 32'hDEADBEEF);
            end
        end
        check("t3_gnt_pattern",   gnt_seen,   16'b0000_1111_0000_1100);
        check("t3_stall_pattern", stall_seen, 16'b0000_1111_0000_1110);
        drive(1'b0, 1'b1, 1'b0, 10'd19, '0, 1'b0, 1'b0, '0, '0);
        check("t3_burst_data", cpu_rdata, 32'hA000_0003);
        drive(1'b0, 1'b1, 1'b0, 10'd21, '0, 1'b0, 1'b0, '0, '0);
        check("t4_burst_data", cpu_rdata, 32'hA000_0005);

        // 5. Reset while a forced window serves a pending debug write.
        for (int c = 0; c < MAX_WAIT; c++)
            drive(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b1, 10'd9, 32'h9999_9999);
        drive(1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b1, 10'd9, 32'h9999_9999);
        check("t5_no_write", mem_we,    1'b0);
        check("t5_gnt",      dbg_gnt,   1'b0);
        check("t5_stall",    cpu_stall, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 10'd9, '0, 1'b1, 1'b1, 10'd9, 32'h9999_9999);
        check("t5_cpu_first",  dbg_gnt,    1'b0);
        check("t5_cpu_stall",  cpu_stall,  1'b0);
        check("t5_not_written", cpu_rdata, 32'h0);
        check("t5_rvalid",     dbg_rvalid, 1'b0);
        check("t5_rdata",      dbg_rdata,  32'h0);
        idle();

        // Randomized traffic with varying CPU load and occasional reset.
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_data = '0;
        for (int i = 0; i < 3000; i++) begin
            int p;
            logic rs, cr;
            p  = (((i / 500) % 3) == 0) ? 30 : ((((i / 500) % 3) == 1) ? 70 : 95);
            rs = ($urandom_range(0, 299) == 0);
            cr = ($urandom_range(0, 99) < p);
            if (!h_req && ($urandom_range(0, 99) < 40)) begin
                h_req  = 1'b1;
                h_we   = $urandom_range(0, 1) == 1;
                h_addr = 10'($urandom_range(0, 15));
                h_data = $urandom;
            end
            drive(rs, cr, $urandom_range(0, 1) == 1, 10'($urandom_range(0, 15)), $urandom,
                  h_req, h_we, h_addr, h_data);
            if (dbg_gnt) h_req = 1'b0;
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
